// File: rtl/light_pkg.sv
// Shared encodings for the multi-phase traffic light controller: FSM states,
// interval-register select codes and per-phase lamp bit offsets.
package light_pkg;

  typedef enum logic [2:0] {
    Green    = 3'd0,
    GreenExt = 3'd1,
    Yellow   = 3'd2,
    Walk     = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    SelBase = 2'd0,
    SelExt  = 2'd1,
    SelYel  = 2'd2,
    SelWalk = 2'd3
  } prog_sel_e;

  localparam int unsigned GREEN_BIT  = 0;
  localparam int unsigned YELLOW_BIT = 1;
  localparam int unsigned RED_BIT    = 2;

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter paced by a tick enable; expire fires on the tick that
// consumes the last remaining count.
module interval_timer #(
  parameter int unsigned TIMER_W = 5,
  parameter int unsigned RST_VAL = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  localparam logic [TIMER_W-1:0] One = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] RstCount = (RST_VAL == 0) ? One : TIMER_W'(RST_VAL);

  logic [TIMER_W-1:0] count_q, count_d;

  assign expire = tick && (count_q == One);
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      // A zero-length interval would never expire, so it runs as one tick.
      count_d = (load_value == '0) ? One : load_value;
    end else if (tick && (count_q > One)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= RstCount;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/multi_phase_light_fsm.sv
// Sequences N_PHASES approaches through green / extended green / yellow, with an
// optional all-red pedestrian walk after the last phase and programmable intervals.
module multi_phase_light_fsm
  import light_pkg::*;
#(
  parameter int unsigned N_PHASES = 2,
  parameter int unsigned TIMER_W  = 5,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_WALK   = 3,
  localparam int unsigned PHASE_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  Sync_Reset,
  input  logic                  Tick,
  input  logic [N_PHASES-1:0]   Sync_Sensor,
  input  logic                  WalkReq,
  input  logic                  Sync_Reprogram,
  input  logic [1:0]            Prog_Sel,
  input  logic [TIMER_W-1:0]    Prog_Value,
  output logic [3*N_PHASES-1:0] Lights,
  output logic                  Walk_Lamp,
  output logic                  WalkReg_Reset,
  output logic [2:0]            State,
  output logic [PHASE_W-1:0]    Phase,
  output logic [TIMER_W-1:0]    Remaining
);

  localparam logic [PHASE_W-1:0] LastPhase = PHASE_W'(N_PHASES - 1);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 walk_pending_q, walk_pending_d;
  logic                 walk_clr_q;
  logic                 enter_walk;
  logic [TIMER_W-1:0]   t_base_q, t_ext_q, t_yel_q, t_walk_q;
  logic                 load, expire;
  logic [TIMER_W-1:0]   load_value, count;

  interval_timer #(
    .TIMER_W (TIMER_W),
    .RST_VAL (T_BASE)
  ) u_timer (
    .clk        (clk),
    .rst        (Sync_Reset),
    .tick       (Tick),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .expire     (expire)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    load       = 1'b0;
    load_value = t_base_q;
    enter_walk = 1'b0;
    if (Sync_Reprogram) begin
      // Restart uses the value being written this edge when it targets base green.
      state_d    = Green;
      phase_d    = '0;
      load       = 1'b1;
      load_value = (prog_sel_e'(Prog_Sel) == SelBase) ? Prog_Value : t_base_q;
    end else if (expire) begin
      load = 1'b1;
      unique case (state_q)
        Green: begin
          if (Sync_Sensor[phase_q]) begin
            state_d    = GreenExt;
            load_value = t_ext_q;
          end else begin
            state_d    = Yellow;
            load_value = t_yel_q;
          end
        end
        GreenExt: begin
          state_d    = Yellow;
          load_value = t_yel_q;
        end
        Yellow: begin
          if (phase_q != LastPhase) begin
            state_d = Green;
            phase_d = phase_q + PHASE_W'(1);
          end else if (walk_pending_q) begin
            state_d    = Walk;
            load_value = t_walk_q;
            enter_walk = 1'b1;
          end else begin
            state_d = Green;
            phase_d = '0;
          end
        end
        default: begin
          state_d = Green;
          phase_d = '0;
        end
      endcase
    end
    // Clear beats a coincident request: that request is the one being served.
    walk_pending_d = enter_walk ? 1'b0 : (walk_pending_q | WalkReq);
  end

  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      state_q        <= Green;
      phase_q        <= '0;
      walk_pending_q <= 1'b0;
      walk_clr_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      walk_pending_q <= walk_pending_d;
      walk_clr_q     <= enter_walk;
    end
  end

  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      t_base_q <= TIMER_W'(T_BASE);
      t_ext_q  <= TIMER_W'(T_EXT);
      t_yel_q  <= TIMER_W'(T_YEL);
      t_walk_q <= TIMER_W'(T_WALK);
    end else if (Sync_Reprogram) begin
      unique case (prog_sel_e'(Prog_Sel))
        SelBase: t_base_q <= Prog_Value;
        SelExt:  t_ext_q  <= Prog_Value;
        SelYel:  t_yel_q  <= Prog_Value;
        SelWalk: t_walk_q <= Prog_Value;
        default: ;
      endcase
    end
  end

  always_comb begin
    Lights = '0;
    for (int p = 0; p < N_PHASES; p++) begin
      Lights[3*p+GREEN_BIT]  = (phase_q == PHASE_W'(p)) &&
                               ((state_q == Green) || (state_q == GreenExt));
      Lights[3*p+YELLOW_BIT] = (phase_q == PHASE_W'(p)) && (state_q == Yellow);
      Lights[3*p+RED_BIT]    = !(Lights[3*p+GREEN_BIT] || Lights[3*p+YELLOW_BIT]);
    end
  end

  assign Walk_Lamp     = (state_q == Walk);
  assign WalkReg_Reset = walk_clr_q;
  assign State         = state_q;
  assign Phase         = phase_q;
  assign Remaining     = count;

endmodule

// File: tb/tb_multi_phase_light_fsm.sv
// Scoreboard bench: each scenario queues the expected sequence of (state, phase, ticks)
// intervals, and the observer pops one per interval and checks lamps, counts and length.
module tb_multi_phase_light_fsm;

  localparam int NP = 3;
  localparam int TW = 5;

  typedef struct {
    logic [2:0] st;
    int         ph;
    int         len;
  } seg_t;

  logic            clk = 1'b0;
  logic            sync_reset = 1'b0;
  logic            tick = 1'b0;
  logic [NP-1:0]   sensor = '0;
  logic            walk_req = 1'b0;
  logic            reprogram = 1'b0;
  logic [1:0]      prog_sel = '0;
  logic [TW-1:0]   prog_value = '0;
  logic [3*NP-1:0] lights;
  logic            walk_lamp;
  logic            walk_rst;
  logic [2:0]      state;
  logic [1:0]      phase;
  logic [TW-1:0]   remaining;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_gap = 1;
  bit   walk_at_expiry = 1'b0;
  seg_t exp_q[$];

  multi_phase_light_fsm #(
    .N_PHASES (NP),
    .TIMER_W  (TW),
    .T_BASE   (6),
    .T_EXT    (3),
    .T_YEL    (2),
    .T_WALK   (3)
  ) dut (
    .clk            (clk),
    .Sync_Reset     (sync_reset),
    .Tick           (tick),
    .Sync_Sensor    (sensor),
    .WalkReq        (walk_req),
    .Sync_Reprogram (reprogram),
    .Prog_Sel       (prog_sel),
    .Prog_Value     (prog_value),
    .Lights         (lights),
    .Walk_Lamp      (walk_lamp),
    .WalkReg_Reset  (walk_rst),
    .State          (state),
    .Phase          (phase),
    .Remaining      (remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3*NP-1:0] exp_lights(input logic [2:0] st, input int ph);
    logic [3*NP-1:0] l;
    l = '0;
    for (int p = 0; p < NP; p++) begin
      if ((st == 3'd0 || st == 3'd1) && p == ph) l[3*p +: 3] = 3'b001;
      else if (st == 3'd2 && p == ph)            l[3*p +: 3] = 3'b010;
      else                                       l[3*p +: 3] = 3'b100;
    end
    return l;
  endfunction

  task automatic push_seg(input logic [2:0] st, input int ph, input int len);
    seg_t s;
    s.st = st; s.ph = ph; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic push_round(input logic [NP-1:0] sens, input int base, input int yel);
    for (int p = 0; p < NP; p++) begin
      push_seg(3'd0, p, base);
      if (sens[p]) push_seg(3'd1, p, 3);
      push_seg(3'd2, p, yel);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    tick = 1'b1;
    cycle();
    sync_reset = 1'b0;
    tick = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_walk();
    walk_req = 1'b1;
    cycle();
    walk_req = 1'b0;
  endtask

  task automatic do_reprogram(input logic [1:0] sel, input logic [TW-1:0] val, input bit tk);
    reprogram = 1'b1; prog_sel = sel; prog_value = val; tick = tk;
    cycle();
    reprogram = 1'b0; tick = 1'b0;
  endtask

  // Pops one expected interval per loop and follows the DUT until it changes state/phase.
  task automatic run_segments(input int n);
    for (int i = 0; i < n; i++) begin
      seg_t s;
      logic [2:0] st0;
      logic [1:0] ph0;
      int ticks, cyc;
      bit done;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: observed state %0d, required a queued entry", state);
        return;
      end
      n_pass++;
      s = exp_q.pop_front();
      n_checks++;
      if (state !== s.st) $display("FAIL entry_state: got %0d want %0d", state, s.st);
      else n_pass++;
      if (s.st != 3'd3) begin
        n_checks++;
        if (phase !== 2'(s.ph)) $display("FAIL entry_phase: got %0d want %0d", phase, s.ph);
        else n_pass++;
      end
      n_checks++;
      if (remaining !== TW'(s.len))
        $display("FAIL entry_remaining: got %0d want %0d", remaining, s.len);
      else n_pass++;
      n_checks++;
      if (lights !== exp_lights(s.st, s.ph))
        $display("FAIL lights: got %b want %b", lights, exp_lights(s.st, s.ph));
      else n_pass++;
      n_checks++;
      if (walk_lamp !== (s.st == 3'd3))
        $display("FAIL walk_lamp: got %b want %b", walk_lamp, (s.st == 3'd3));
      else n_pass++;
      n_checks++;
      if (walk_rst !== (s.st == 3'd3))
        $display("FAIL walkreg_reset_entry: got %b want %b", walk_rst, (s.st == 3'd3));
      else n_pass++;
      st0 = state; ph0 = phase; ticks = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 400) begin
        tick = ((cyc % tick_gap) == tick_gap - 1);
        walk_req = walk_at_expiry && tick && remaining == 1 && state == 3'd2 && phase == 2'd2;
        cycle();
        cyc++;
        if (tick) ticks++;
        tick = 1'b0;
        walk_req = 1'b0;
        if (state !== st0 || phase !== ph0) done = 1'b1;
        else begin
          n_checks++;
          if (walk_rst !== 1'b0) $display("FAIL walkreg_reset_hold: got %b want 0", walk_rst);
          else n_pass++;
        end
      end
      n_checks++;
      if (!done) $display("FAIL interval_timeout: state %0d still active, want %0d ticks",
                          st0, s.len);
      else if (ticks != s.len)
        $display("FAIL interval_length: state %0d phase %0d got %0d ticks want %0d",
                 s.st, s.ph, ticks, s.len);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++;
    if (phase !== 2'd0) $display("FAIL reset_phase: got %0d want 0", phase); else n_pass++;
    n_checks++;
    if (remaining !== 5'd6) $display("FAIL reset_remaining: got %0d want 6", remaining);
    else n_pass++;
    n_checks++;
    if (lights !== 9'b100_100_001) $display("FAIL reset_lights: got %b want 100100001", lights);
    else n_pass++;
    n_checks++;
    if (walk_lamp !== 1'b0 || walk_rst !== 1'b0)
      $display("FAIL reset_walk: got lamp %b rst %b want 0 0", walk_lamp, walk_rst);
    else n_pass++;
  endtask

  task automatic test_default_cycle();
    do_reset();
    tick_gap = 2;
    push_round('0, 6, 2);
    push_seg(3'd0, 0, 6);
    run_segments(7);
    tick_gap = 1;
  endtask

  task automatic test_sensor();
    do_reset();
    sensor = 3'b010;
    push_round(3'b010, 6, 2);
    push_seg(3'd0, 0, 6);
    run_segments(8);
    sensor = '0;
  endtask

  task automatic test_walk();
    do_reset();
    pulse_walk();
    push_round('0, 6, 2);
    push_seg(3'd3, 0, 3);
    push_round('0, 6, 2);
    push_seg(3'd0, 0, 6);
    run_segments(14);
  endtask

  task automatic test_walk_coincide();
    do_reset();
    pulse_walk();
    walk_at_expiry = 1'b1;
    push_round('0, 6, 2);
    push_seg(3'd3, 0, 3);
    run_segments(7);
    walk_at_expiry = 1'b0;
    push_round('0, 6, 2);
    push_seg(3'd0, 0, 6);
    run_segments(7);
  endtask

  task automatic test_reprogram();
    do_reset();
    push_seg(3'd0, 0, 6); push_seg(3'd2, 0, 2); push_seg(3'd0, 1, 6);
    run_segments(3);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    n_checks++;
    if (state !== 3'd2 || phase !== 2'd1 || remaining !== 5'd1)
      $display("FAIL mid_yellow: got st %0d ph %0d rem %0d want 2 1 1", state, phase, remaining);
    else n_pass++;
    do_reprogram(2'd0, 5'd10, 1'b0);
    push_seg(3'd0, 0, 10); push_seg(3'd2, 0, 2); push_seg(3'd0, 1, 10);
    run_segments(3);
    // Strobe lands on the yellow expiry edge; the restart must win.
    tick = 1'b1;
    cycle();
    do_reprogram(2'd0, 5'd0, 1'b1);
    push_seg(3'd0, 0, 1); push_seg(3'd2, 0, 2); push_seg(3'd0, 1, 1);
    run_segments(3);
    do_reprogram(2'd2, 5'd4, 1'b0);
    push_seg(3'd0, 0, 1); push_seg(3'd2, 0, 4);
    run_segments(2);
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    do_reprogram(2'd3, 5'd5, 1'b0);
    do_reprogram(2'd0, 5'd4, 1'b0);
    pulse_walk();
    push_round('0, 4, 2);
    run_segments(6);
    n_checks++;
    if (state !== 3'd3 || remaining !== 5'd5)
      $display("FAIL walk_reprogrammed: got st %0d rem %0d want 3 5", state, remaining);
    else n_pass++;
    tick = 1'b1; walk_req = 1'b1;
    cycle();
    tick = 1'b0; walk_req = 1'b0;
    do_reset();
    n_checks++;
    if (state !== 3'd0 || phase !== 2'd0 || remaining !== 5'd6)
      $display("FAIL reset_from_walk: got st %0d ph %0d rem %0d want 0 0 6",
               state, phase, remaining);
    else n_pass++;
    n_checks++;
    if (walk_lamp !== 1'b0 || lights !== 9'b100_100_001)
      $display("FAIL reset_from_walk_lamps: got lamp %b lights %b want 0 100100001",
               walk_lamp, lights);
    else n_pass++;
    push_round('0, 6, 2);
    push_seg(3'd0, 0, 6);
    run_segments(7);
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_sensor();
    test_walk();
    test_walk_coincide();
    test_reprogram();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
